// File: rtl/cpu_pkg.sv
// Shared constants and state encoding for the fetch stage.
// FETCH_STEP_EN adds the single-step wait state to the encoding.
package cpu_pkg;

   localparam int             CPU_ADDR_W   = 8;
   localparam int             CPU_INST_W   = 8;
   localparam logic [7:0]     CPU_RESET_PC = 8'h00;
   localparam logic [7:0]     OP_HALT      = 8'h10;

   typedef enum logic [1:0] {
      S_FETCH     = 2'd0,
      S_EXEC      = 2'd1,
      S_HALT      = 2'd2
`ifdef FETCH_STEP_EN
      ,
      S_STEP_WAIT = 2'd3
`endif
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake plus the fetch <-> control-unit signals.
// FETCH_STEP_EN adds the step input.
interface fetch_unit_if #(
   parameter int ADDR_W = cpu_pkg::CPU_ADDR_W,
   parameter int INST_W = cpu_pkg::CPU_INST_W
);
   logic              imem_rd;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [INST_W-1:0] imem_data;
   logic [INST_W-1:0] inst;
   logic              inst_valid;
   logic              pc_en;
   logic              pc_ld_en;
   logic [ADDR_W-1:0] br_addr;
   logic [ADDR_W-1:0] pc_out;
   logic              halted;
`ifdef FETCH_STEP_EN
   logic              step;
`endif

   modport master (
      output imem_rd, imem_addr, inst, inst_valid, pc_out, halted,
      input  imem_ack, imem_data, pc_en, pc_ld_en, br_addr
`ifdef FETCH_STEP_EN
      , input step
`endif
   );

   modport slave (
      input  imem_rd, imem_addr, inst, inst_valid, pc_out, halted,
      output imem_ack, imem_data, pc_en, pc_ld_en, br_addr
`ifdef FETCH_STEP_EN
      , output step
`endif
   );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: async reset to RESET_PC, branch load, increment or hold.
module pc_reg #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld,
   input  logic              inc,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic [ADDR_W-1:0] pc
);

   // Increment wraps naturally at 2^ADDR_W; load takes priority over increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (ld) begin
         pc <= ld_addr;
      end else if (inc) begin
         pc <= pc + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns PC and IR, fetches over req/ack, presents one INST per instruction.
// FETCH_STEP_EN inserts a STEP-gated wait after every non-halting EXEC.
//
// state       | meaning
// S_FETCH     | imem_rd high at PC, waiting for imem_ack
// S_EXEC      | one cycle: INST valid, PC_EN/PC_LD_EN/BR_ADDR sampled
// S_HALT      | stopped until reset
// S_STEP_WAIT | PC already advanced, waiting for step (FETCH_STEP_EN only)
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = CPU_ADDR_W,
   parameter int                INST_W   = CPU_INST_W,
   parameter logic [ADDR_W-1:0] RESET_PC = CPU_RESET_PC
) (
   input  logic          clk,
   input  logic          rst,
   fetch_unit_if.master  bus
);

   fetch_state_t      state;
   logic [INST_W-1:0] ir;
   logic [ADDR_W-1:0] pc;
   logic              inst_valid_q;
   logic              halted_q;
   logic              in_exec;

   assign in_exec = (state == S_EXEC);

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk     (clk),
      .rst     (rst),
      .ld      (in_exec && bus.pc_en && bus.pc_ld_en),
      .inc     (in_exec && bus.pc_en && !bus.pc_ld_en),
      .ld_addr (bus.br_addr),
      .pc      (pc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_FETCH;
         ir           <= '0;
         inst_valid_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (bus.imem_ack) begin
                  ir           <= bus.imem_data;
                  inst_valid_q <= 1'b1;
                  state        <= S_EXEC;
               end
            end
            S_EXEC: begin
               inst_valid_q <= 1'b0;
               if (!bus.pc_en) begin
                  halted_q <= 1'b1;
                  state    <= S_HALT;
               end else begin
`ifdef FETCH_STEP_EN
                  state <= S_STEP_WAIT;
`else
                  state <= S_FETCH;
`endif
               end
            end
`ifdef FETCH_STEP_EN
            S_STEP_WAIT: begin
               if (bus.step) begin
                  state <= S_FETCH;
               end
            end
`endif
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

   // Gating with rst drops the request the moment reset rises, not at the next edge.
   assign bus.imem_rd    = (state == S_FETCH) && !rst;
   assign bus.imem_addr  = pc;
   assign bus.inst       = ir;
   assign bus.inst_valid = inst_valid_q;
   assign bus.pc_out     = pc;
   assign bus.halted     = halted_q;

endmodule
